gemm_dispatch: RTL and testbench

Compute-side instruction dispatcher directly upstream of the `gemm` core. It buffers 128-bit compute instructions, enforces the pop/push dependency-token protocol encoded in instruction bits [6:3], presents each GEMM instruction (opcode 2) to `gemm` with a one-cycle start pulse, and waits for completion before releasing tokens. FINISH (opcode 3) is handled locally; all other opcodes are flagged as errors.

---
 rtl/gemm_dispatch.sv | 201 ++++++++++++++++++++
 tb/tb_gemm_dispatch.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_dispatch.sv
// Compute-side dispatcher in front of the gemm core: queues instructions, enforces
// the pop/push dependency-token protocol, issues GEMM work and retires FINISH locally.
module gemm_dispatch #(
    parameter int INS_WIDTH     = 128,
    parameter int FIFO_DEPTH    = 4,
    parameter int TOK_CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 insn_in_valid,
    output logic                 insn_in_ready,
    input  logic [INS_WIDTH-1:0] insn_in_data,
    input  logic                 prev_tok_in,
    input  logic                 next_tok_in,
    output logic                 prev_tok_out,
    output logic                 next_tok_out,
    output logic [INS_WIDTH-1:0] insn_out,
    output logic                 insn_start,
    input  logic                 gemm_done,
    output logic                 finish,
    output logic                 busy,
    output logic [1:0]           err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [TOK_CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [2:0] OP_GEMM   = 3'd2;
    localparam logic [2:0] OP_FINISH = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DEP,
        S_ISSUE,
        S_EXEC,
        S_PUSH
    } state_t;

    state_t                 state;
    logic [INS_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W:0]         count;
    logic                   full;
    logic                   empty;
    logic                   wr_en;
    logic                   rd_en;
    logic [INS_WIDTH-1:0]   cur;
    logic [TOK_CNT_WIDTH-1:0] prev_cnt;
    logic [TOK_CNT_WIDTH-1:0] next_cnt;
    logic                   deps_met;
    logic                   take_prev;
    logic                   take_next;
    logic                   err_op;
    logic                   err_sat;
    logic [TOK_CNT_WIDTH:0] prev_upd;
    logic [TOK_CNT_WIDTH:0] next_upd;

    // Handshake: a word transfers on any rising edge where insn_in_valid && insn_in_ready;
    // ready depends only on occupancy, never on valid, and a same-cycle pop does not raise it.
    assign full          = (count == FULL_CNT);
    assign empty         = (count == '0);
    assign insn_in_ready = !full;
    assign wr_en         = insn_in_valid && !full;
    assign rd_en         = (state == S_IDLE) && !empty;
    assign err           = {err_sat, err_op};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= insn_in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Bits [3]/[4] of the held instruction request a prev/next token before it may proceed.
    assign deps_met  = (!cur[3] || (prev_cnt != '0)) && (!cur[4] || (next_cnt != '0));
    assign take_prev = (state == S_WAIT_DEP) && deps_met && cur[3];
    assign take_next = (state == S_WAIT_DEP) && deps_met && cur[4];

    // Returns {saturated, new_count}; a simultaneous arrival and consumption cancel out.
    function automatic logic [TOK_CNT_WIDTH:0] tok_update(
        input logic [TOK_CNT_WIDTH-1:0] cnt,
        input logic                     inc,
        input logic                     dec
    );
        logic [TOK_CNT_WIDTH:0] res;
        res = {1'b0, cnt};
        if (inc && !dec) begin
            if (cnt == CNT_MAX) begin
                res = {1'b1, cnt};
            end else begin
                res = {1'b0, cnt + 1'b1};
            end
        end else if (dec && !inc) begin
            res = {1'b0, cnt - 1'b1};
        end
        return res;
    endfunction

    assign prev_upd = tok_update(prev_cnt, prev_tok_in, take_prev);
    assign next_upd = tok_update(next_cnt, next_tok_in, take_next);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_cnt <= '0;
            next_cnt <= '0;
            err_sat  <= 1'b0;
        end else begin
            prev_cnt <= prev_upd[TOK_CNT_WIDTH-1:0];
            next_cnt <= next_upd[TOK_CNT_WIDTH-1:0];
            if (prev_upd[TOK_CNT_WIDTH] || next_upd[TOK_CNT_WIDTH]) begin
                err_sat <= 1'b1;
            end
        end
    end

    // All pulse outputs are registered on the transition into the state that owns them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cur          <= '0;
            insn_out     <= '0;
            insn_start   <= 1'b0;
            prev_tok_out <= 1'b0;
            next_tok_out <= 1'b0;
            finish       <= 1'b0;
            busy         <= 1'b0;
            err_op       <= 1'b0;
        end else begin
            insn_start   <= 1'b0;
            prev_tok_out <= 1'b0;
            next_tok_out <= 1'b0;
            finish       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        cur   <= mem[rd_ptr];
                        busy  <= 1'b1;
                        state <= S_WAIT_DEP;
                    end
                end
                S_WAIT_DEP: begin
                    if (deps_met) begin
                        if (cur[2:0] == OP_GEMM) begin
                            insn_start <= 1'b1;
                            state      <= S_ISSUE;
                        end else begin
                            // FINISH and illegal opcodes skip gemm but still release tokens.
                            prev_tok_out <= cur[5];
                            next_tok_out <= cur[6];
                            finish       <= (cur[2:0] == OP_FINISH);
                            if (cur[2:0] != OP_FINISH) begin
                                err_op <= 1'b1;
                            end
                            state <= S_PUSH;
                        end
                    end
                end
                S_ISSUE: begin
                    insn_out <= cur;
                    state    <= S_EXEC;
                end
                S_EXEC: begin
                    if (gemm_done) begin
                        prev_tok_out <= cur[5];
                        next_tok_out <= cur[6];
                        state        <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gemm_dispatch.sv
// Directed bench for gemm_dispatch: drivers push expected starts/pulses into queues,
// a negedge monitor pops and compares whenever the DUT presents an event.
module tb_gemm_dispatch;

    localparam int W = 128;

    logic         clk = 1'b0;
    logic         rst;
    logic         insn_in_valid;
    logic         insn_in_ready;
    logic [W-1:0] insn_in_data;
    logic         prev_tok_in;
    logic         next_tok_in;
    logic         prev_tok_out;
    logic         next_tok_out;
    logic [W-1:0] insn_out;
    logic         insn_start;
    logic         gemm_done;
    logic         finish;
    logic         busy;
    logic [1:0]   err;

    gemm_dispatch #(
        .INS_WIDTH    (W),
        .FIFO_DEPTH   (4),
        .TOK_CNT_WIDTH(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .insn_in_valid(insn_in_valid),
        .insn_in_ready(insn_in_ready),
        .insn_in_data (insn_in_data),
        .prev_tok_in  (prev_tok_in),
        .next_tok_in  (next_tok_in),
        .prev_tok_out (prev_tok_out),
        .next_tok_out (next_tok_out),
        .insn_out     (insn_out),
        .insn_start   (insn_start),
        .gemm_done    (gemm_done),
        .finish       (finish),
        .busy         (busy),
        .err          (err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_pass  = 0;

    logic [W-1:0] exp_q[$];
    int           exp_start_cyc_q[$];
    logic [2:0]   exp_pulse_q[$];
    int           exp_pulse_cyc_q[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic exp_start(input logic [W-1:0] w, input int c);
        exp_q.push_back(w);
        exp_start_cyc_q.push_back(c);
    endtask

    task automatic exp_pulse(input logic [2:0] bits, input int c);
        exp_pulse_q.push_back(bits);
        exp_pulse_cyc_q.push_back(c);
    endtask

    logic         insn_chk_pend = 1'b0;
    logic [W-1:0] insn_chk_val;

    always @(negedge clk) begin : monitor
        int         c;
        logic [2:0] e;
        if (rst) begin
            insn_chk_pend = 1'b0;
        end else begin
            if (insn_chk_pend) begin
                check("insn_out_after_start", insn_out, insn_chk_val);
                insn_chk_pend = 1'b0;
            end
            if (insn_start) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_start", W'(insn_start), '0);
                end else begin
                    insn_chk_val = exp_q.pop_front();
                    c = exp_start_cyc_q.pop_front();
                    if (c >= 0) check("start_cycle", W'(cyc), W'(c));
                    insn_chk_pend = 1'b1;
                end
            end
            if (prev_tok_out || next_tok_out || finish) begin
                if (exp_pulse_q.size() == 0) begin
                    check("unexpected_pulse", W'({finish, next_tok_out, prev_tok_out}), '0);
                end else begin
                    e = exp_pulse_q.pop_front();
                    c = exp_pulse_cyc_q.pop_front();
                    check("pulse_bits", W'({finish, next_tok_out, prev_tok_out}), W'(e));
                    check("pulse_cycle", W'(cyc), W'(c));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic send(input logic [W-1:0] w, output int acc_cyc);
        int waited = 0;
        insn_in_valid = 1'b1;
        insn_in_data  = w;
        while (!insn_in_ready && waited < 200) begin
            tick();
            waited++;
        end
        check("send_ready", W'(insn_in_ready), W'(1));
        acc_cyc = cyc;
        tick();
        insn_in_valid = 1'b0;
    endtask

    task automatic run_one(input string name);
        int waited = 0;
        while (!insn_start && waited < 50) begin
            tick();
            waited++;
        end
        check(name, W'(insn_start), W'(1));
        tick();
        gemm_done = 1'b1;
        tick();
        gemm_done = 1'b0;
    endtask

    // dep = {push_next, push_prev, pop_next, pop_prev}
    function automatic logic [W-1:0] mk(input logic [2:0] op, input logic [3:0] dep,
                                        input logic [12:0] uop_bgn, input logic [13:0] uop_end,
                                        input logic [13:0] it_out, input logic [13:0] it_in);
        logic [W-1:0] w;
        w = '0;
        w[2:0]     = op;
        w[6:3]     = dep;
        w[20:8]    = uop_bgn;
        w[34:21]   = uop_end;
        w[48:35]   = it_out;
        w[62:49]   = it_in;
        w[73:63]   = 11'd1;
        w[84:74]   = 11'd1;
        w[95:85]   = 11'd4;
        w[106:96]  = 11'd4;
        w[117:107] = 11'd4;
        w[127:118] = 10'd4;
        return w;
    endfunction

    // ---------------- stimulus ----------------
    int           n, acc, t, d, m, k;
    logic [W-1:0] w, w2, wf, wi;
    logic [W-1:0] wb[6];

    initial begin
        rst           = 1'b1;
        insn_in_valid = 1'b0;
        insn_in_data  = '0;
        prev_tok_in   = 1'b0;
        next_tok_in   = 1'b0;
        gemm_done     = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_ready", W'(insn_in_ready), W'(1));
        check("rst_insn_out", insn_out, '0);
        check("rst_start", W'(insn_start), '0);
        check("rst_prev_tok_out", W'(prev_tok_out), '0);
        check("rst_next_tok_out", W'(next_tok_out), '0);
        check("rst_finish", W'(finish), '0);
        check("rst_busy", W'(busy), '0);
        check("rst_err", W'(err), '0);

        // Single GEMM, no dependencies, gemm_done at N+6
        w = mk(3'd2, 4'b0000, 13'd1, 14'd10, 14'd4, 14'd4);
        n = cyc;
        exp_start(w, n + 3);
        send(w, acc);
        check("t1_accept_cycle", W'(acc), W'(n));
        wait_until(n + 6);
        gemm_done = 1'b1;
        tick();
        gemm_done = 1'b0;
        check("t1_busy_push", W'(busy), W'(1));
        tick();
        check("t1_busy_idle", W'(busy), '0);
        check("t1_insn_out_hold", insn_out, w);

        // pop_prev with no token: hold 20 cycles, then a token releases it
        w = mk(3'd2, 4'b0001, 13'd20, 14'd30, 14'd2, 14'd2);
        send(w, acc);
        n = acc;
        wait_until(n + 22);
        check("t2_busy_waiting", W'(busy), W'(1));
        t = cyc;
        exp_start(w, t + 2);
        prev_tok_in = 1'b1;
        tick();
        prev_tok_in = 1'b0;
        check("t2_prev_cnt_seen", W'(dut.prev_cnt), W'(1));
        tick();
        tick();
        check("t2_prev_cnt_consumed", W'(dut.prev_cnt), '0);
        gemm_done = 1'b1;
        tick();
        gemm_done = 1'b0;
        tick();
        tick();

        // push_prev + push_next: both token pulses exactly at D+1
        w = mk(3'd2, 4'b1100, 13'd5, 14'd6, 14'd1, 14'd1);
        n = cyc;
        exp_start(w, n + 3);
        send(w, acc);
        wait_until(n + 5);
        d = cyc;
        exp_pulse(3'b011, d + 1);
        gemm_done = 1'b1;
        tick();
        gemm_done = 1'b0;
        tick();
        tick();
        check("t3_busy_idle", W'(busy), '0);

        // Backpressure: 6 back-to-back words while gemm is held busy
        for (int i = 0; i < 6; i++) wb[i] = mk(3'd2, 4'b0000, 13'(100 + i), 14'(200 + i), 14'd1, 14'd1);
        m = cyc;
        exp_start(wb[0], m + 3);
        exp_start(wb[1], m + 12);
        for (int i = 2; i < 6; i++) exp_start(wb[i], -1);
        insn_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            insn_in_data = wb[i];
            check("t4_ready_open", W'(insn_in_ready), W'(1));
            tick();
        end
        insn_in_data = wb[5];
        check("t4_ready_full", W'(insn_in_ready), '0);
        tick();
        tick();
        check("t4_ready_held", W'(insn_in_ready), '0);
        tick();
        gemm_done = 1'b1;
        tick();
        gemm_done = 1'b0;
        k = 0;
        while (!insn_in_ready && k < 50) begin
            tick();
            k++;
        end
        check("t4_ready_return_cycle", W'(cyc), W'(m + 11));
        tick();
        insn_in_valid = 1'b0;
        for (int i = 1; i < 6; i++) run_one("t4_start_seen");
        tick();
        tick();
        check("t4_busy_idle", W'(busy), '0);

        // FINISH then illegal opcode 5 (with push_next)
        check("t5_err_clean", W'(err), '0);
        wf = mk(3'd3, 4'b0000, 13'd0, 14'd0, 14'd0, 14'd0);
        wi = mk(3'd5, 4'b1000, 13'd7, 14'd8, 14'd1, 14'd1);
        n = cyc;
        exp_pulse(3'b100, n + 3);
        exp_pulse(3'b010, n + 6);
        send(wf, acc);
        send(wi, acc);
        check("t5_second_accept", W'(acc), W'(n + 1));
        wait_until(n + 7);
        check("t5_err_illegal", W'(err), W'(2'b01));
        check("t5_busy_idle", W'(busy), '0);
        repeat (5) tick();
        check("t5_err_sticky", W'(err), W'(2'b01));

        // Token saturation on next_cnt
        next_tok_in = 1'b1;
        repeat (15) tick();
        next_tok_in = 1'b0;
        check("t6_next_cnt_max", W'(dut.next_cnt), W'(15));
        check("t6_err_before_sat", W'(err), W'(2'b01));
        next_tok_in = 1'b1;
        tick();
        next_tok_in = 1'b0;
        check("t6_err_sat", W'(err), W'(2'b11));
        check("t6_next_cnt_stuck", W'(dut.next_cnt), W'(15));

        // Reset during EXEC with a second word still queued
        w  = mk(3'd2, 4'b1110, 13'd9, 14'd11, 14'd3, 14'd3);
        w2 = mk(3'd2, 4'b0000, 13'd12, 14'd13, 14'd1, 14'd1);
        n = cyc;
        exp_start(w, n + 3);
        send(w, acc);
        send(w2, acc);
        wait_until(n + 5);
        check("t7_busy_exec", W'(busy), W'(1));
        check("t7_next_cnt_consumed", W'(dut.next_cnt), W'(14));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t7_ready", W'(insn_in_ready), W'(1));
        check("t7_insn_out", insn_out, '0);
        check("t7_start", W'(insn_start), '0);
        check("t7_tokens", W'({prev_tok_out, next_tok_out}), '0);
        check("t7_finish", W'(finish), '0);
        check("t7_busy", W'(busy), '0);
        check("t7_err", W'(err), '0);
        check("t7_counts", W'({dut.prev_cnt, dut.next_cnt}), '0);
        check("t7_queue_empty", W'(dut.count), '0);
        gemm_done = 1'b1;
        tick();
        gemm_done = 1'b0;
        repeat (10) tick();
        check("t7_stays_idle", W'(busy), '0);

        check("start_queue_drained", W'(exp_q.size()), '0);
        check("pulse_queue_drained", W'(exp_pulse_q.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
